// File: rtl/instruction_sequencer.sv
// instruction_sequencer
// Program sequencer for the MiniCPU instruction path. It buffers a short
// program of {opcode, data} words that arrive over a valid/ready load port.
// On START it issues those words in order to the decoder over a valid/ready
// issue handshake.
//
// Build macro INVALID_TRAP_EN:
//   defined   - an opcode of 12..15 moves the sequencer into TRAP (ERR=1).
//               It stays there until PROG_CLR.
//   undefined - an opcode of 12..15 is skipped with a single bubble cycle.
//               ERR is tied low.
module instruction_sequencer #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ld_valid,
    output logic                     ld_ready,
    input  logic [4+DATA_W-1:0]      ld_word,
    input  logic                     prog_clr,
    input  logic                     start,
    input  logic                     halt,
    output logic [3:0]               instruction,
    output logic [DATA_W-1:0]        data,
    output logic                     issue_valid,
    input  logic                     issue_ready,
    output logic                     busy,
    output logic                     done,
    output logic                     err,
    output logic [$clog2(DEPTH)-1:0] pc,
    output logic [$clog2(DEPTH):0]   len
);

    localparam int          AW        = $clog2(DEPTH);
    localparam int          WORD_W    = 4 + DATA_W;
    localparam logic [3:0]  LAST_OP   = 4'd11;
    localparam logic [AW:0] LEN_ONE   = (AW+1)'(1);
    localparam logic [AW:0] LEN_FULL  = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] PC_ONE  = AW'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
`ifdef INVALID_TRAP_EN
        ,
        S_TRAP
`endif
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [AW-1:0]       pc_next;
    logic [AW:0]         len_next;
    logic                fetch;
    logic [AW-1:0]       fetch_idx;
    logic [AW-1:0]       pc_inc;
    logic [WORD_W-1:0]   rd_word;
    logic                ld_fire;
    logic                op_invalid;
    logic                at_last;
    logic [WORD_W-1:0]   mem [DEPTH];

    // Status outputs and helper terms decoded from the current registered state.
    always_comb begin
        busy        = (state == S_RUN);
        done        = (state == S_DONE);
        ld_ready    = (state == S_IDLE) && (len < LEN_FULL);
        op_invalid  = (instruction > LAST_OP);
        issue_valid = busy && !op_invalid;
        ld_fire     = ld_valid && ld_ready && !prog_clr;
        at_last     = ({1'b0, pc} == (len - LEN_ONE));
        pc_inc      = pc + PC_ONE;
`ifdef INVALID_TRAP_EN
        err         = (state == S_TRAP);
`else
        err         = 1'b0;
`endif
    end

    // Program store read port: it feeds the instruction/data registers.
    assign rd_word = mem[fetch_idx];

    // Next-state, PC, length and fetch control.
    // NOTE: every output of this block is given a default before the case
    // statement. As a result no path leaves a variable unassigned, and no
    // latch is inferred.
    always_comb begin
        state_next = state;
        pc_next    = pc;
        len_next   = len;
        fetch      = 1'b0;
        fetch_idx  = pc;
        case (state)
            S_IDLE: begin
                if (prog_clr) begin
                    len_next = '0;
                end else begin
                    if (ld_fire) begin
                        len_next = len + LEN_ONE;
                    end
                    if (start) begin
                        if (len != '0) begin
                            state_next = S_RUN;
                            pc_next    = '0;
                            fetch      = 1'b1;
                            fetch_idx  = '0;
                        end else begin
                            state_next = S_DONE;
                        end
                    end
                end
            end
            S_RUN: begin
                if (halt) begin
                    state_next = S_IDLE;
                    pc_next    = '0;
`ifdef INVALID_TRAP_EN
                end else if (op_invalid) begin
                    state_next = S_TRAP;
                end else if (issue_valid && issue_ready) begin
`else
                end else if (op_invalid || (issue_valid && issue_ready)) begin
`endif
                    if (at_last) begin
                        state_next = S_DONE;
                    end else begin
                        pc_next   = pc_inc;
                        fetch     = 1'b1;
                        fetch_idx = pc_inc;
                    end
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
                pc_next    = '0;
            end
`ifdef INVALID_TRAP_EN
            S_TRAP: begin
                if (prog_clr) begin
                    state_next = S_IDLE;
                    len_next   = '0;
                    pc_next    = '0;
                end
            end
`endif
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // State register.
    // NOTE: sequential state uses non-blocking assignments. All registers then
    // update together at the edge, whatever order the blocks are evaluated in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // PC, program length and the registered instruction/data presented downstream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= '0;
            len         <= '0;
            instruction <= '0;
            data        <= '0;
        end else begin
            pc  <= pc_next;
            len <= len_next;
            if (fetch) begin
                instruction <= rd_word[WORD_W-1 -: 4];
                data        <= rd_word[DATA_W-1:0];
            end
        end
    end

    // Program store write port: each accepted load word goes to mem[len].
    // NOTE: the program store has no reset. LEN marks which entries are
    // meaningful, so clearing the array would only add reset fan-out.
    always_ff @(posedge clk) begin
        if (ld_fire) begin
            mem[len[AW-1:0]] <= ld_word;
        end
    end

endmodule

// File: tb/tb_instruction_sequencer.sv
// Self-checking bench for instruction_sequencer.
// A queue-based reference model holds the loaded program. For each run cycle
// the model works out which word must be presented, from the program rules:
// in-order issue, skip or trap on opcodes 12..15, and DONE after the last word.
module tb_instruction_sequencer;

    localparam int DEPTH  = 16;
    localparam int DATA_W = 4;
    localparam int AW     = $clog2(DEPTH);
    localparam int W      = 4 + DATA_W;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              ld_valid;
    logic              ld_ready;
    logic [W-1:0]      ld_word;
    logic              prog_clr;
    logic              start;
    logic              halt;
    logic [3:0]        instruction;
    logic [DATA_W-1:0] data;
    logic              issue_valid;
    logic              issue_ready;
    logic              busy;
    logic              done;
    logic              err;
    logic [AW-1:0]     pc;
    logic [AW:0]       len;

    int checks   = 0;
    int failures = 0;

    // Reference model: the program as loaded, in load order.
    logic [W-1:0] prog[$];

    instruction_sequencer #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ld_valid    (ld_valid),
        .ld_ready    (ld_ready),
        .ld_word     (ld_word),
        .prog_clr    (prog_clr),
        .start       (start),
        .halt        (halt),
        .instruction (instruction),
        .data        (data),
        .issue_valid (issue_valid),
        .issue_ready (issue_ready),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .pc          (pc),
        .len         (len)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Advance to 1 time unit after the next rising edge. Inputs are driven
    // there, and outputs are sampled there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input logic [W-1:0] w);
        ld_valid = 1'b1;
        ld_word  = w;
        check("ld_ready_load", ld_ready, 1);
        tick();
        ld_valid = 1'b0;
        prog.push_back(w);
    endtask

    task automatic load_random(input int n, input int invalid_pct);
        logic [3:0]        op;
        logic [DATA_W-1:0] d;
        for (int i = 0; i < n; i++) begin
            if (int'($urandom_range(99)) < invalid_pct) op = 4'($urandom_range(15, 12));
            else                                        op = 4'($urandom_range(11, 0));
            d = DATA_W'($urandom);
            load_word({op, d});
        end
        check("len_after_load", len, prog.size());
    endtask

    task automatic clear_program();
        prog_clr = 1'b1;
        tick();
        prog_clr = 1'b0;
        prog.delete();
        check("len_after_clr", len, 0);
    endtask

    // Start the program, then follow it cycle by cycle against the model.
    // hold_pos/hold_cycles force ISSUE_READY low while that word is presented.
    // halt_on is the 0-based handshake that HALT coincides with (-1 for none).
    task automatic run_program(input int stall_pct, input int hold_pos, input int hold_cycles, input int halt_on);
        int           pos    = 0;
        int           hs     = 0;
        int           held   = 0;
        int           cycles = 0;
        logic [W-1:0] w;
        logic         exp_valid;
        logic         ready_now;
        logic         do_halt;
        start = 1'b1;
        tick();
        start = 1'b0;
        if (prog.size() == 0) begin
            check("empty_done", done, 1);
            check("empty_busy", busy, 0);
            check("empty_valid", issue_valid, 0);
            tick();
            check("empty_done_drop", done, 0);
            check("empty_valid2", issue_valid, 0);
            return;
        end
        forever begin
            if (cycles >= 400) begin
                check("run_timeout", cycles, 0);
                return;
            end
            w         = prog[pos];
            exp_valid = (w[W-1 -: 4] <= 4'd11);
            check("busy", busy, 1);
            check("done_in_run", done, 0);
            check("pc", pc, pos);
            check("instruction", instruction, w[W-1 -: 4]);
            check("data", data, w[DATA_W-1:0]);
            check("issue_valid", issue_valid, exp_valid);
            if (hold_pos == pos && held < hold_cycles) begin
                ready_now = 1'b0;
                held++;
            end else begin
                ready_now = (int'($urandom_range(99)) >= stall_pct);
            end
            do_halt     = (halt_on == hs) && exp_valid && ready_now;
            issue_ready = ready_now;
            halt        = do_halt;
            tick();
            cycles++;
            halt = 1'b0;
            if (do_halt) begin
                check("halt_busy", busy, 0);
                check("halt_valid", issue_valid, 0);
                check("halt_pc", pc, 0);
                check("halt_done", done, 0);
                check("halt_len", len, prog.size());
                issue_ready = 1'b0;
                return;
            end
            if (exp_valid) begin
                if (ready_now) begin
                    hs++;
                    pos++;
                end
            end else begin
`ifdef INVALID_TRAP_EN
                check("trap_err", err, 1);
                check("trap_busy", busy, 0);
                check("trap_valid", issue_valid, 0);
                check("trap_pc", pc, pos);
                start       = 1'b1;
                halt        = 1'b1;
                issue_ready = 1'b0;
                tick();
                start = 1'b0;
                halt  = 1'b0;
                check("trap_hold_err", err, 1);
                check("trap_hold_pc", pc, pos);
                check("trap_hold_busy", busy, 0);
                prog_clr = 1'b1;
                tick();
                prog_clr = 1'b0;
                prog.delete();
                check("trap_clr_err", err, 0);
                check("trap_clr_len", len, 0);
                check("trap_clr_pc", pc, 0);
                check("trap_clr_ld_ready", ld_ready, 1);
                return;
`else
                pos++;
`endif
            end
            if (pos == prog.size()) begin
                check("done_pulse", done, 1);
                check("done_busy", busy, 0);
                check("done_valid", issue_valid, 0);
                check("done_err", err, 0);
                check("done_len", len, prog.size());
                issue_ready = 1'b0;
                tick();
                check("done_drop", done, 0);
                check("idle_busy", busy, 0);
                check("idle_pc", pc, 0);
                check("idle_ld_ready", ld_ready, prog.size() < DEPTH);
                return;
            end
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        ld_valid    = 1'b0;
        ld_word     = '0;
        prog_clr    = 1'b0;
        start       = 1'b0;
        halt        = 1'b0;
        issue_ready = 1'b0;
        #12;
        check("rst_ld_ready", ld_ready, 1);
        check("rst_len", len, 0);
        check("rst_pc", pc, 0);
        check("rst_instruction", instruction, 0);
        check("rst_data", data, 0);
        check("rst_issue_valid", issue_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Three-word program issued back to back.
        load_word(8'h15);
        load_word(8'h23);
        load_word(8'h40);
        check("len_three", len, 3);
        run_program(0, -1, 0, -1);

        // Same program, downstream stalls four cycles on the second word.
        run_program(0, 1, 4, -1);
        check("len_kept", len, 3);

        // PROG_CLR wins over a same-cycle load and START.
        ld_valid = 1'b1;
        ld_word  = 8'h77;
        prog_clr = 1'b1;
        start    = 1'b1;
        tick();
        ld_valid = 1'b0;
        prog_clr = 1'b0;
        start    = 1'b0;
        prog.delete();
        check("clr_wins_len", len, 0);
        check("clr_wins_busy", busy, 0);
        check("clr_wins_done", done, 0);

        // START with an empty program.
        run_program(0, -1, 0, -1);

        // Fill to capacity, then offer one word too many.
        load_random(DEPTH, 0);
        check("full_ld_ready", ld_ready, 0);
        ld_valid = 1'b1;
        ld_word  = 8'h99;
        tick();
        ld_valid = 1'b0;
        check("full_len", len, DEPTH);
        check("full_ld_ready2", ld_ready, 0);

        // HALT on the third handshake, then rerun the whole program from word 0.
        run_program(30, -1, 0, 2);
        run_program(20, -1, 0, -1);

        // Program containing an invalid opcode.
        clear_program();
        load_word(8'h11);
        load_word(8'hD0);
        load_word(8'h40);
        run_program(0, -1, 0, -1);

        // Random programs with random stalls and occasional invalid opcodes.
        for (int k = 0; k < 8; k++) begin
            clear_program();
            load_random(int'($urandom_range(DEPTH, 1)), 20);
            run_program(int'($urandom_range(50, 0)), -1, 0, -1);
        end

        // Asynchronous reset in the middle of a run.
        clear_program();
        load_random(4, 0);
        start = 1'b1;
        tick();
        start       = 1'b0;
        issue_ready = 1'b1;
        tick();
        tick();
        issue_ready = 1'b0;
        check("pre_rst_pc", pc, 2);
        check("pre_rst_busy", busy, 1);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", issue_valid, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_pc", pc, 0);
        check("async_rst_len", len, 0);
        check("async_rst_ld_ready", ld_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        prog.delete();
        tick();
        check("post_rst_len", len, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
